// File: rtl/shared_logic_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : shared_logic_arbiter
//  Description : Two-requester round-robin arbiter in front of a one-bit
//                shared logic unit. The granted requester walks through
//                IDLE -> GRANT -> EXEC -> DONE; operands are captured in
//                GRANT, the result is loaded in EXEC and held with valid in
//                DONE until the owner drops its request.
//                Optional feature macro: ARB_TIMEOUT_EN (force release of
//                the unit after eight DONE cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module shared_logic_arbiter (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Pin breakout
    logic w_clk;
    logic w_rst;
    logic w_req0;
    logic w_req1;
    logic w_opa;
    logic w_opb;
    logic w_opsel;
    logic w_unused;

    assign w_clk    = io_in[0];
    assign w_rst    = io_in[1];
    assign w_req0   = io_in[2];
    assign w_req1   = io_in[3];
    assign w_opa    = io_in[4];
    assign w_opb    = io_in[5];
    assign w_opsel  = io_in[6];
    assign w_unused = io_in[7];

    logic [1:0] r_state;
    logic       r_ptr;
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_opa;
    logic       r_opb;
    logic       r_opsel;
    logic       r_result;
    logic       r_valid;
    logic [2:0] r_done_cnt;

    logic w_winner;
    logic w_owner_req;
    logic w_timeout;
    logic w_busy;

    // With both requests high the pointer decides; otherwise the lone requester wins
    assign w_winner    = (w_req0 && w_req1) ? r_ptr : w_req1;
    // The owner is identified by its grant bit, so its request is selected from that
    assign w_owner_req = r_gnt1 ? w_req1 : w_req0;
    assign w_busy      = (r_state != S_IDLE);

`ifdef ARB_TIMEOUT_EN
    logic [2:0] r_hold;

    // Hold counter: zeroed on the EXEC->DONE edge, counts every DONE cycle
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_hold <= 3'd0;
        end else if (r_state == S_EXEC) begin
            r_hold <= 3'd0;
        end else if (r_state == S_DONE) begin
            r_hold <= r_hold + 3'd1;
        end
    end

    assign w_timeout = (r_state == S_DONE) && (r_hold == 3'd7);
`else
    assign w_timeout = 1'b0;
`endif

    // Arbitration FSM, operand capture, result register and completion counter
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= 1'b0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_opa      <= 1'b0;
            r_opb      <= 1'b0;
            r_opsel    <= 1'b0;
            r_result   <= 1'b0;
            r_valid    <= 1'b0;
            r_done_cnt <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req0 || w_req1) begin
                        r_gnt0  <= ~w_winner;
                        r_gnt1  <= w_winner;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT, S_EXEC: begin
                    if (!w_owner_req) begin
                        // Abort: no result, no count, but the other side gets priority
                        r_ptr   <= ~r_gnt1;
                        r_gnt0  <= 1'b0;
                        r_gnt1  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_state == S_GRANT) begin
                        r_opa   <= w_opa;
                        r_opb   <= w_opb;
                        r_opsel <= w_opsel;
                        r_state <= S_EXEC;
                    end else begin
                        r_result <= r_opsel ? (r_opa | r_opb) : (r_opa & (r_opa | r_opb));
                        r_valid  <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!w_owner_req || w_timeout) begin
                        // Result register keeps its value; only valid is withdrawn
                        r_ptr      <= ~r_gnt1;
                        r_gnt0     <= 1'b0;
                        r_gnt1     <= 1'b0;
                        r_valid    <= 1'b0;
                        r_done_cnt <= r_done_cnt + 3'd1;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_out = {r_done_cnt, w_busy, r_valid, r_result, r_gnt1, r_gnt0};

endmodule
`default_nettype wire

// File: tb/tb_shared_logic_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shared_logic_arbiter
//  Description : Self-checking bench for shared_logic_arbiter. A
//                transaction-level reference model (owner, age in cycles,
//                pointer, counter) predicts io_out after every edge; directed
//                scenarios add hand-derived checks. Honours ARB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_logic_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_LIMIT = 8;
`else
    localparam int HOLD_LIMIT = 0;
`endif

    logic       clk;
    logic [6:0] in_hi;
    logic [7:0] io_in;
    logic [7:0] io_out;

    assign io_in = {in_hi, clk};

    shared_logic_arbiter dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state: owner -1 = nobody, age 0 = GRANT, 1 = EXEC, >=2 = DONE
    int m_owner;
    int m_age;
    bit m_ptr;
    int m_cnt;
    bit m_valid;
    bit m_result;
    bit m_cap;

    function automatic bit rb();
        return $urandom_range(0, 1) != 0;
    endfunction

    function automatic logic [7:0] m_out();
        return {3'(m_cnt), m_owner >= 0, m_valid, m_result, m_owner == 1, m_owner == 0};
    endfunction

    task automatic model_edge(input bit rst, input bit r0, input bit r1,
                              input bit a, input bit b, input bit sel);
        bit oreq;
        if (rst) begin
            m_owner = -1; m_age = 0; m_ptr = 0; m_cnt = 0;
            m_valid = 0; m_result = 0; m_cap = 0;
        end else if (m_owner < 0) begin
            if (r0 || r1) begin
                m_owner = (r0 && r1) ? int'(m_ptr) : (r1 ? 1 : 0);
                m_age   = 0;
            end
        end else begin
            oreq = (m_owner == 1) ? r1 : r0;
            if (m_age >= 2 && (!oreq || (HOLD_LIMIT > 0 && m_age - 2 == HOLD_LIMIT - 1))) begin
                m_cnt   = (m_cnt + 1) % 8;
                m_ptr   = (m_owner == 0);
                m_owner = -1;
                m_valid = 0;
            end else if (!oreq) begin
                m_ptr   = (m_owner == 0);
                m_owner = -1;
            end else if (m_age == 0) begin
                m_cap = sel ? (a | b) : (a & (a | b));
                m_age = 1;
            end else if (m_age == 1) begin
                m_result = m_cap;
                m_valid  = 1;
                m_age    = 2;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic check_m(input string tag, input logic [7:0] mask, input logic [7:0] exp);
        checks++;
        assert ((io_out & mask) === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b (mask %b)", tag, io_out & mask, exp, mask);
        end
    endtask

    // One clock: drive inputs, advance model on the edge, compare 1 time unit later
    task automatic step(input bit rst, input bit r0, input bit r1,
                        input bit a, input bit b, input bit sel);
        in_hi = {rb(), sel, b, a, r1, r0, rst};
        @(posedge clk);
        model_edge(rst, r0, r1, a, b, sel);
        #1;
        cyc++;
        check_m($sformatf("model_cycle%0d", cyc), 8'hFF, m_out());
    endtask

    // Full transaction for one requester; operands only meaningful in the GRANT cycle
    task automatic txn(input bit w, input bit a, input bit b, input bit sel);
        step(0, !w, w, rb(), rb(), rb());
        step(0, !w, w, a, b, sel);
        step(0, !w, w, rb(), rb(), rb());
        step(0, 0, 0, rb(), rb(), rb());
    endtask

    initial begin
        clk   = 0;
        in_hi = 7'd0;
        m_owner = -1; m_age = 0; m_ptr = 0; m_cnt = 0;
        m_valid = 0; m_result = 0; m_cap = 0;

        // Reset state
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 1);
        check_m("reset_state", 8'hFF, 8'h00);

        // Basic transaction: A=1 B=0 OR -> 1
        step(0, 1, 0, 1, 0, 1);
        check_m("basic_gnt0", 8'h1F, 8'h11);
        step(0, 1, 0, 1, 0, 1);
        step(0, 1, 0, 0, 0, 0);
        check_m("basic_valid", 8'h1F, 8'h1D);
        step(0, 0, 0, 0, 0, 0);
        check_m("basic_release", 8'hFB, 8'h20);
        step(0, 1, 1, 0, 0, 0);
        check_m("basic_ptr1", 8'h13, 8'h12);

        // Round robin under continuous contention
        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 1, rb(), rb(), rb());
            check_m($sformatf("rr_grant%0d", k), 8'h13, (k % 2 == 0) ? 8'h11 : 8'h12);
            step(0, 1, 1, rb(), rb(), rb());
            step(0, 1, 1, rb(), rb(), rb());
            check_m($sformatf("rr_valid%0d", k), 8'h1B, (k % 2 == 0) ? 8'h19 : 8'h1A);
            step(0, k % 2 == 1, k % 2 == 0, rb(), rb(), rb());
        end

        // Operand function: A=0 B=1 with AND-OR then OR
        step(1, 0, 0, 0, 0, 0);
        for (int s = 0; s < 2; s++) begin
            step(0, 1, 0, rb(), rb(), rb());
            step(0, 1, 0, 0, 1, s[0]);
            step(0, 1, 0, rb(), rb(), rb());
            check_m($sformatf("opfunc_sel%0d", s), 8'h0C, (s == 1) ? 8'h0C : 8'h08);
            step(0, 0, 0, 0, 0, 0);
        end

        // Abort during EXEC
        step(0, 0, 1, 1, 1, 1);
        step(0, 0, 1, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0);
        check_m("abort_idle", 8'hFB, 8'h40);
        step(0, 1, 1, 0, 0, 0);
        check_m("abort_ptr0", 8'h13, 8'h11);

        // Reset in DONE with count 5, then counter wrap
        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) txn(k % 2 == 1, rb(), rb(), rb());
        step(0, 1, 0, 1, 1, 1);
        step(0, 1, 0, 1, 1, 1);
        step(0, 1, 0, 1, 1, 1);
        check_m("done_cnt5", 8'hE8, 8'hA8);
        step(1, 1, 0, 1, 1, 1);
        check_m("rst_in_done", 8'hFF, 8'h00);
        for (int k = 0; k < 9; k++) txn(rb(), rb(), rb(), rb());
        check_m("cnt_wrap", 8'hE0, 8'h20);

        // Long hold in DONE
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 1, 0);
        step(0, 1, 0, 1, 1, 0);
        step(0, 1, 0, 1, 1, 0);
        for (int i = 1; i <= 24; i++) begin
            step(0, 1, 0, rb(), rb(), rb());
`ifdef ARB_TIMEOUT_EN
            if (i == 7) check_m("timeout_still_valid", 8'hF8, 8'h18);
            if (i == 8) check_m("timeout_release", 8'hF8, 8'h20);
`else
            if (i == 22) check_m("hold_valid", 8'hF8, 8'h18);
`endif
        end

        // Randomized traffic
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, rb(), rb(), rb());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shared_logic_arbiter.md
SHARED_LOGIC_ARBITER -- requirements
Module: shared_logic_arbiter

Interface
REQ-001 Ports SHALL be io_in [7:0] input and io_out [7:0] output, matching the standard user-module pinout.
REQ-002 io_in[0]  input  1  clock; all state updates on its rising edge.
REQ-003 io_in[1]  input  1  reset; synchronous, active-high.
REQ-004 io_in[2]  input  1  req0; requester 0 request.
REQ-005 io_in[3]  input  1  req1; requester 1 request.
REQ-006 io_in[4]  input  1  opa; operand A from the granted requester.
REQ-007 io_in[5]  input  1  opb; operand B from the granted requester.
REQ-008 io_in[6]  input  1  opsel; 0 = A AND (A OR B), 1 = A OR B.
REQ-009 io_in[7]  input  1  unused; SHALL be ignored.
REQ-010 io_out[0] output 1  gnt0; requester 0 owns the shared logic unit.
REQ-011 io_out[1] output 1  gnt1; requester 1 owns the shared logic unit.
REQ-012 io_out[2] output 1  result; registered unit output.
REQ-013 io_out[3] output 1  valid; result is valid for the granted requester.
REQ-014 io_out[4] output 1  busy; FSM not in IDLE.
REQ-015 io_out[7:5] output 3  done_cnt; completed-transaction counter.

Function
REQ-016 FSM states SHALL be IDLE, GRANT, EXEC and DONE, with exactly one state active per cycle.
REQ-017 IDLE: if any req is high, the FSM SHALL select a winner, assert its gnt on the next edge, and move to GRANT; otherwise it stays in IDLE.
REQ-018 Arbitration SHALL be round-robin via a 1-bit pointer.
- Pointer names the preferred requester.
- With both req high, the pointer's requester wins.
- With one req high, that requester wins regardless of the pointer.
REQ-019 GRANT (one cycle): opa, opb and opsel SHALL be captured into internal registers; next state is EXEC.
REQ-020 EXEC (one cycle): result SHALL be loaded from the captured operands per opsel; next state is DONE.
REQ-021 DONE: valid SHALL be 1 and result held stable.
- When the winner's req is low, the FSM SHALL go to IDLE, clear gnt/valid, increment done_cnt and set the pointer to the other requester.
REQ-022 Latency SHALL be fixed: req sampled high in IDLE at edge N gives gnt at N+1, operand capture at N+1 (GRANT), result/valid at N+3 (DONE).
REQ-023 Exactly one gnt SHALL be high at a time; gnt stays high from GRANT through DONE.
REQ-024 The loser's req SHALL be ignored until the FSM returns to IDLE; there is no preemption.
REQ-025 Abort: if the winner's req is low while in GRANT or EXEC, the FSM SHALL go to IDLE next edge.
- No valid pulse.
- done_cnt is unchanged.
- Pointer is set to the other requester.
REQ-026 done_cnt SHALL wrap 7 -> 0 on increment.
REQ-027 Operand inputs SHALL be ignored outside the GRANT cycle.

Reset
REQ-028 When reset is high at a clock edge, from any state (including mid-transaction), the FSM SHALL enter IDLE and apply these reset values:
- gnt0, gnt1, result, valid, busy: 0.
- done_cnt: 0.
- pointer: requester 0.
- captured operands: 0.
REQ-029 Reset SHALL take priority over all other transitions; the first arbitration occurs at the first edge after reset is low.

Configuration
REQ-030 Macro ARB_TIMEOUT_EN defined: a 3-bit hold counter SHALL clear on DONE entry and increment each DONE cycle.
- If the winner's req is still high when the counter reaches 7 (the eighth DONE cycle), the FSM SHALL force release to IDLE with the normal done_cnt increment and pointer flip.
REQ-031 Macro ARB_TIMEOUT_EN undefined: no hold counter SHALL exist, and DONE is held indefinitely while the winner's req stays high.

Verification
REQ-032 Reset, then req0=1, opa=1, opb=0, opsel=1, req0 dropped after valid -> gnt0 at cycle 1, result=1 and valid=1 at cycle 3, done_cnt=1, pointer=1.
REQ-033 req0=req1=1 from reset, each dropping req after its valid -> grants alternate gnt0, gnt1, gnt0; never both high.
REQ-034 opa=0, opb=1, opsel=0 -> result=0; opa=0, opb=1, opsel=1 -> result=1.
REQ-035 req1 dropped during EXEC -> IDLE next cycle, valid never high, done_cnt unchanged, pointer=0.
REQ-036 Reset asserted in DONE with done_cnt=5 -> next cycle all outputs 0; nine full transactions from reset -> done_cnt=1 (wrap).
REQ-037 With ARB_TIMEOUT_EN, req0 held high -> forced release after 8 DONE cycles; without the macro, valid stays high for 20+ cycles.
